dma_stream_arbiter: RTL and testbench

- Packet-aware round-robin arbiter.
- Merges up to Ports card-to-host AXIS streams into the single 64-bit stream that feeds the XDMA header adjuster.
- Each input carries OpenFC-framed packets:
  - zero or more routing header words (TDATA[63:56]==8'h01),
  - then one length word (top byte != 8'h01, TDATA[31:0] = payload word count L),
  - then L payload words.
- A grant is held for a whole packet and is never switched mid-packet.

---
 rtl/dma_stream_arbiter.sv | 121 ++++++++++++
 tb/tb_dma_stream_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_arbiter.sv
// Packet-aware round-robin arbiter merging several OpenFC-framed AXIS streams
// into one 64-bit stream; a grant is held from the first header to the last payload word.
module dma_stream_arbiter #(
  parameter int Ports    = 4,
  parameter int PortBits = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [Ports-1:0]      S_AXIS_TVALID,
  output logic [Ports-1:0]      S_AXIS_TREADY,
  input  logic [Ports-1:0]      S_AXIS_TLAST,
  input  logic [64*Ports-1:0]   S_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [63:0]           M_AXIS_TDATA,
  output logic [PortBits-1:0]   GRANT,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

  state_t              state, state_next;
  logic [PortBits-1:0] grant, grant_next;
  logic [31:0]         count, count_next;
  logic                active, beat;
  logic                pick_found;
  logic [PortBits-1:0] pick_idx;
  logic                sel_valid, sel_last;
  logic [63:0]         sel_data;

  // First requesting port when scanning base+1, base+2, ... modulo Ports.
  function automatic logic [PortBits:0] rr_pick(input logic [Ports-1:0] req,
                                                input logic [PortBits-1:0] base);
    logic [PortBits:0] res;
    int                off;
    int                best_off;
    res      = '0;
    best_off = Ports;
    for (int j = 0; j < Ports; j++) begin
      off = (j + 2 * Ports - 1 - int'(base)) % Ports;
      if (req[j] && (off < best_off)) begin
        best_off = off;
        res      = {1'b1, PortBits'(j)};
      end
    end
    return res;
  endfunction

  assign {pick_found, pick_idx} = rr_pick(S_AXIS_TVALID, grant);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < Ports; i++) begin
      if (grant == PortBits'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_last  = S_AXIS_TLAST[i];
        sel_data  = S_AXIS_TDATA[64*i +: 64];
      end
    end
  end

  // Gating with RST_N keeps a word from being consumed in the cycle the packet is abandoned.
  assign active        = RST_N && (state != IDLE);
  assign M_AXIS_TVALID = active && sel_valid;
  assign M_AXIS_TDATA  = sel_data;
  assign M_AXIS_TLAST  = sel_last;
  assign beat          = M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    S_AXIS_TREADY = '0;
    for (int i = 0; i < Ports; i++) begin
      S_AXIS_TREADY[i] = active && M_AXIS_TREADY && (grant == PortBits'(i));
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    count_next = count;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = HDR;
        end
      end
      HDR: begin
        if (beat && (sel_data[63:56] != 8'h01)) begin
          count_next = sel_data[31:0];
          state_next = (sel_data[31:0] == 32'd0) ? IDLE : PAY;
        end
      end
      PAY: begin
        if (beat) begin
          count_next = count - 32'd1;
          if (count == 32'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      grant <= PortBits'(Ports - 1);
      count <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      count <= count_next;
    end
  end

  assign GRANT = grant;
  assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Randomized bench: per-port word queues feed the arbiter, and a packet-level
// model (whole-packet lengths, round-robin order) predicts every output cycle.
module tb_dma_stream_arbiter;
  localparam int P  = 4;
  localparam int PB = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [P-1:0]    s_tvalid = '0;
  logic [P-1:0]    s_tready;
  logic [P-1:0]    s_tlast = '0;
  logic [64*P-1:0] s_tdata = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic            m_tlast;
  logic [63:0]     m_tdata;
  logic [PB-1:0]   grant;
  logic            busy;

  always #5 clk = ~clk;

  dma_stream_arbiter #(.Ports(P), .PortBits(PB)) dut (
    .CLK(clk), .RST_N(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TDATA(s_tdata),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TDATA(m_tdata),
    .GRANT(grant), .BUSY(busy)
  );

  logic [63:0] q [P][$];
  int   checks = 0;
  int   errors = 0;
  int   gap_pct = 0;
  int   rdy_pct = 100;
  logic rst_drv = 1'b0;
  bit   m_busy = 1'b0;
  int   m_grant = P - 1;
  int   m_left = 0;
  int   order[$];
  int   obs_beats = 0;
  int   enq_words = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Whole-packet length in beats: leading headers, the length word, then L payload words.
  function automatic int pkt_len(input int p);
    int          n;
    logic [63:0] w;
    n = 0;
    while (n < q[p].size()) begin
      w = q[p][n];
      if (w[63:56] != 8'h01) break;
      n++;
    end
    w = q[p][n];
    return n + 1 + int'(w[31:0]);
  endfunction

  function automatic logic [63:0] pack_order();
    logic [63:0] r;
    r = '0;
    foreach (order[i]) r = (r << 4) | 64'(order[i]);
    return r;
  endfunction

  task automatic add_pkt(input int p, input int nh, input int len);
    for (int i = 0; i < nh; i++) q[p].push_back({8'h01, 8'(i), 16'($urandom), 32'($urandom)});
    q[p].push_back({8'h5A, 8'(p), 16'($urandom), 32'(len)});
    for (int i = 0; i < len; i++) q[p].push_back({32'($urandom), 32'($urandom)});
    enq_words += nh + 1 + len;
  endtask

  task automatic cycle();
    logic [63:0] exp_ready;
    bit          ev;
    bit          found;
    int          pp;
    for (int p = 0; p < P; p++) begin
      s_tvalid[p]          = (q[p].size() > 0) && ($urandom_range(99) >= gap_pct);
      s_tdata[64*p +: 64]  = (q[p].size() > 0) ? q[p][0] : {32'($urandom), 32'($urandom)};
      s_tlast[p]           = 1'($urandom);
    end
    m_tready = ($urandom_range(99) < rdy_pct);
    rst_n    = rst_drv;
    @(negedge clk);
    ev        = rst_n && m_busy && s_tvalid[m_grant];
    exp_ready = '0;
    if (rst_n && m_busy && m_tready) exp_ready[m_grant] = 1'b1;
    check("m_tvalid", 64'(m_tvalid), 64'(ev));
    check("s_tready", 64'(s_tready), exp_ready);
    check("grant", 64'(grant), 64'(m_grant));
    check("busy", 64'(busy), 64'(m_busy));
    if (ev) begin
      check("m_tdata", m_tdata, q[m_grant][0]);
      check("m_tlast", 64'(m_tlast), 64'(s_tlast[m_grant]));
    end
    if (m_tvalid && m_tready) obs_beats++;
    @(posedge clk);
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_grant = P - 1;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= P; k++) begin
        pp = (m_grant + k) % P;
        if (!found && s_tvalid[pp]) begin
          found   = 1'b1;
          m_grant = pp;
          m_busy  = 1'b1;
          m_left  = pkt_len(pp);
          order.push_back(pp);
        end
      end
    end else if (s_tvalid[m_grant] && m_tready) begin
      void'(q[m_grant].pop_front());
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_busy) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'(0));
  endtask

  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();
    rst_n = 1'b1;
    #1;
    check("rst_grant", 64'(grant), 64'(P - 1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(m_tvalid), 64'(0));
    check("rst_ready", 64'(s_tready), 64'(0));

    // Single port, two headers, three payload words.
    order.delete();
    add_pkt(1, 2, 3);
    drain(200);
    check("s1_n", 64'(order.size()), 64'(1));
    check("s1_order", pack_order(), 64'h1);

    // Two competing ports from reset.
    do_reset();
    order.delete();
    add_pkt(0, 1, 4);
    add_pkt(2, 1, 4);
    drain(200);
    check("s2_n", 64'(order.size()), 64'(2));
    check("s2_order", pack_order(), 64'h02);

    // All ports continuously busy, short packets.
    do_reset();
    order.delete();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < P; p++) add_pkt(p, 0, 1);
    drain(400);
    check("s3_n", 64'(order.size()), 64'(8));
    check("s3_order", pack_order(), 64'h01230123);

    // Zero-length packets; rotation continues past port 3 to port 0.
    do_reset();
    order.delete();
    add_pkt(3, 0, 0);
    drain(50);
    add_pkt(3, 0, 0);
    add_pkt(0, 0, 0);
    drain(50);
    check("s4_n", 64'(order.size()), 64'(3));
    check("s4_order", pack_order(), 64'h303);

    // Long packet under random backpressure and source gaps, with background traffic.
    gap_pct = 30;
    rdy_pct = 25;
    order.delete();
    add_pkt(2, 2, 200);
    for (int r = 0; r < 3; r++) begin
      add_pkt(0, $urandom_range(2), $urandom_range(5));
      add_pkt(1, $urandom_range(2), $urandom_range(5));
      add_pkt(3, $urandom_range(2), $urandom_range(5));
    end
    drain(20000);
    check("s5_n", 64'(order.size()), 64'(10));
    gap_pct = 0;
    rdy_pct = 100;

    // Reset after the second payload word; leftover words re-parse as L=0 packets.
    do_reset();
    order.delete();
    q[1].push_back({8'h5A, 8'h01, 16'h0, 32'd10});
    for (int k = 0; k < 10; k++) q[1].push_back({8'h00, 24'(k + 1), 32'd0});
    enq_words += 11;
    n = 0;
    while (q[1].size() > 8 && n < 100) begin
      cycle();
      n++;
    end
    check("s6_wait", 64'(n >= 100), 64'(0));
    check("s6_busy_before", 64'(busy), 64'(1));
    do_reset();
    rst_n = 1'b1;
    #1;
    check("s6_valid", 64'(m_tvalid), 64'(0));
    check("s6_grant", 64'(grant), 64'(P - 1));
    check("s6_busy", 64'(busy), 64'(0));
    drain(200);
    check("s6_n", 64'(order.size()), 64'(9));
    check("s6_order", pack_order(), 64'h111111111);

    check("total_beats", 64'(obs_beats), 64'(enq_words));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
